// File: rtl/peripheral_ahb4_slave_mem_if.sv
// AHB4 slave-side bus bundle for peripheral_ahb4_slave_mem.
//
// Handshake: an address phase is taken on a rising HCLK edge only when
// HREADY=1; together with HSEL=1 and HTRANS[1]=1 that edge is a transfer.
// A data phase lasts while HREADYOUT=0 and ends on the first rising edge
// seen with HREADYOUT=1. HRESP=1 marks that data phase as ERROR. The
// master holds HWDATA stable for the whole data phase.
interface peripheral_ahb4_slave_mem_if #(
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [HDATA_SIZE-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
    output HTRANS, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
    input  HTRANS, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/peripheral_ahb4_slave_mem.sv
// AHB4 memory slave: MEM_DEPTH words of HDATA_SIZE bits, byte-lane writes,
// optional wait states per OKAY beat, two-cycle ERROR response for
// oversize, misaligned or out-of-range transfers.
module peripheral_ahb4_slave_mem #(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  peripheral_ahb4_slave_mem_if.slave        bus,
  output logic [1:0]                        dbg_state
);
  localparam int NBYTES    = HDATA_SIZE / 8;
  localparam int ADDR_LSB  = $clog2(NBYTES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int OFF_W     = (ADDR_LSB > 0) ? ADDR_LSB : 1;
  localparam int OOR_SHIFT = ADDR_LSB + IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              dp_valid;
  logic              dp_write;
  logic [IDX_W-1:0]  dp_idx;
  logic [OFF_W-1:0]  dp_off;
  logic [2:0]        dp_size;
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
  logic [NBYTES-1:0] byte_en;
  logic              addr_sample, accept, acc_err;
  logic              size_err, align_err, range_err;
  logic              complete, wr_en;
  logic              hreadyout, hresp;
  logic              unused_bus;

  // Burst type, protection, lock and the SEQ/NONSEQ distinction do not
  // change how this slave behaves.
  assign unused_bus = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  // Address phases are only taken when no data phase of ours is stalled.
  assign addr_sample = bus.HREADY && (state == ST_IDLE || state == ST_ERR2);
  assign accept      = addr_sample && bus.HSEL && bus.HTRANS[1];

  // Legality checks on the address phase being accepted.
  always_comb begin
    size_err  = (int'(bus.HSIZE) > ADDR_LSB);
    align_err = ((int'(bus.HADDR) & ((1 << bus.HSIZE) - 1)) != 0);
    range_err = |(bus.HADDR >> OOR_SHIFT);
    acc_err   = size_err || align_err || range_err;
  end

  // FSM state and wait counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, wait counter and response outputs.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (state == ST_ERR2) hresp = 1'b1;
        state_n = ST_IDLE;
        if (accept) begin
          if (acc_err) begin
            state_n = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_n = ST_WAIT;
            cnt_n   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        cnt_n     = 4'(cnt - 4'd1);
        if (cnt == 4'd1) state_n = ST_IDLE;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_n   = ST_ERR2;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Data-phase controls: loaded on every sampled address phase, dropped
  // once an OKAY data phase has completed with nothing new behind it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_off   <= '0;
      dp_size  <= 3'd0;
    end else if (addr_sample) begin
      dp_valid <= accept && !acc_err;
      dp_write <= bus.HWRITE;
      dp_idx   <= IDX_W'(bus.HADDR >> ADDR_LSB);
      dp_off   <= OFF_W'(int'(bus.HADDR) & (NBYTES - 1));
      dp_size  <= bus.HSIZE;
    end else if (state == ST_IDLE) begin
      dp_valid <= 1'b0;
    end
  end

  // An OKAY data phase completes in the IDLE-state cycle that follows it.
  assign complete = (state == ST_IDLE) && dp_valid;
  assign wr_en    = complete && dp_write;

  // Byte lanes covered by the registered size and address offset.
  always_comb begin
    byte_en = '0;
    for (int b = 0; b < NBYTES; b++) begin
      byte_en[b] = ((b >> dp_size) == (int'(dp_off) >> dp_size));
    end
  end

  // Storage array; writes land on the edge that ends the data phase.
  always_ff @(posedge HCLK) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (wr_en && byte_en[b]) mem[dp_idx][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = (complete && !dp_write) ? mem[dp_idx] : '0;
  assign dbg_state     = state;
endmodule

// File: tb/tb_peripheral_ahb4_slave_mem.sv
// Directed bench for peripheral_ahb4_slave_mem: three instances with 0, 2
// and 3 wait states sharing one stimulus set, HSEL steered by cur.
module tb_peripheral_ahb4_slave_mem;
  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  peripheral_ahb4_slave_mem_if bus0 ();
  peripheral_ahb4_slave_mem_if bus1 ();
  peripheral_ahb4_slave_mem_if bus2 ();
  logic [1:0] dbg0, dbg1, dbg2;

  logic        hsel, hwrite;
  logic [15:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [1:0]  cur;
  logic        m_ready, m_resp;
  logic [31:0] m_rdata;
  logic [1:0]  m_dbg;

  int total = 0;
  int bad   = 0;
  int          lows;
  logic        lresp, fresp;
  logic [31:0] rd, wait_rd;

  assign bus0.HSEL = hsel && (cur == 2'd0);
  assign bus1.HSEL = hsel && (cur == 2'd1);
  assign bus2.HSEL = hsel && (cur == 2'd2);
  assign {bus0.HADDR, bus1.HADDR, bus2.HADDR}    = {3{haddr}};
  assign {bus0.HWDATA, bus1.HWDATA, bus2.HWDATA} = {3{hwdata}};
  assign {bus0.HWRITE, bus1.HWRITE, bus2.HWRITE} = {3{hwrite}};
  assign {bus0.HSIZE, bus1.HSIZE, bus2.HSIZE}    = {3{hsize}};
  assign {bus0.HTRANS, bus1.HTRANS, bus2.HTRANS} = {3{htrans}};
  assign {bus0.HBURST, bus1.HBURST, bus2.HBURST} = {3{3'b011}};
  assign {bus0.HPROT, bus1.HPROT, bus2.HPROT}    = {3{4'b0011}};
  assign {bus0.HMASTLOCK, bus1.HMASTLOCK, bus2.HMASTLOCK} = 3'b000;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;

  always_comb begin
    case (cur)
      2'd1:    begin m_ready = bus1.HREADYOUT; m_resp = bus1.HRESP; m_rdata = bus1.HRDATA; m_dbg = dbg1; end
      2'd2:    begin m_ready = bus2.HREADYOUT; m_resp = bus2.HRESP; m_rdata = bus2.HRDATA; m_dbg = dbg2; end
      default: begin m_ready = bus0.HREADYOUT; m_resp = bus0.HRESP; m_rdata = bus0.HRDATA; m_dbg = dbg0; end
    endcase
  end

  peripheral_ahb4_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0), .dbg_state(dbg0));
  peripheral_ahb4_slave_mem #(.WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1), .dbg_state(dbg1));
  peripheral_ahb4_slave_mem #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2), .dbg_state(dbg2));

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 16'h0; hsize = 3'd0;
  endtask

  task automatic set_addr(input logic [1:0] tr, input logic w,
                          input logic [15:0] a, input logic [2:0] sz);
    hsel = 1'b1; htrans = tr; hwrite = w; haddr = a; hsize = sz;
  endtask

  // Lets the accepting edge pass, then follows the data phase until the
  // cycle with HREADYOUT=1; returns at the negedge of that cycle.
  task automatic data_phase(input logic [31:0] wd);
    lows = 0; lresp = 1'b0; wait_rd = 32'h0;
    @(posedge HCLK);
    @(negedge HCLK);
    hwdata = wd;
    set_idle();
    while (m_ready !== 1'b1 && lows < 20) begin
      lows++;
      lresp = lresp | m_resp;
      wait_rd = wait_rd | m_rdata;
      @(negedge HCLK);
    end
    fresp = m_resp;
    rd = m_rdata;
  endtask

  task automatic single(input logic w, input logic [15:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
    set_addr(2'b10, w, a, sz);
    data_phase(wd);
    @(negedge HCLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cur = 2'(k);
      #1;
      total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL reset_hreadyout dut%0d: got %b want 1", k, m_ready); end
      total++; if (m_resp !== 1'b0) begin bad++; $display("FAIL reset_hresp dut%0d: got %b want 0", k, m_resp); end
      total++; if (m_rdata !== 32'h0) begin bad++; $display("FAIL reset_hrdata dut%0d: got %h want 0", k, m_rdata); end
      total++; if (m_dbg !== 2'd0) begin bad++; $display("FAIL reset_state dut%0d: got %0d want 0", k, m_dbg); end
    end
    cur = 2'd0;
  endtask

  task automatic test_word_rw();
    cur = 2'd0;
    single(1'b1, 16'h0010, 3'd2, 32'hDEADBEEF);
    total++; if (lows !== 0 || fresp !== 1'b0) begin bad++; $display("FAIL word_write: lows=%0d resp=%b want 0/0", lows, fresp); end
    single(1'b0, 16'h0010, 3'd2, 32'h0);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_read: got %h want deadbeef", rd); end
    total++; if (lows !== 0 || fresp !== 1'b0) begin bad++; $display("FAIL word_read_timing: lows=%0d resp=%b want 0/0", lows, fresp); end
    total++; if (m_rdata !== 32'h0) begin bad++; $display("FAIL idle_hrdata: got %h want 0", m_rdata); end
  endtask

  task automatic test_byte_lanes();
    cur = 2'd0;
    single(1'b1, 16'h0013, 3'd0, 32'hA5000000);
    total++; if (lows !== 0 || fresp !== 1'b0) begin bad++; $display("FAIL byte_write: lows=%0d resp=%b want 0/0", lows, fresp); end
    single(1'b0, 16'h0010, 3'd2, 32'h0);
    total++; if (rd !== 32'hA5ADBEEF) begin bad++; $display("FAIL byte_read: got %h want a5adbeef", rd); end
    single(1'b1, 16'h0014, 3'd2, 32'h11223344);
    single(1'b1, 16'h0016, 3'd1, 32'hBEEF0000);
    single(1'b0, 16'h0014, 3'd2, 32'h0);
    total++; if (rd !== 32'hBEEF3344) begin bad++; $display("FAIL half_read: got %h want beef3344", rd); end
  endtask

  task automatic test_burst_wait();
    logic [31:0] exp_q[$];
    cur = 2'd1;
    set_addr(2'b10, 1'b1, 16'h0020, 3'd2);
    for (int i = 0; i < 4; i++) begin
      data_phase(32'(i + 1));
      total++; if (lows !== 2 || lresp !== 1'b0 || fresp !== 1'b0) begin bad++; $display("FAIL burst_write beat%0d: lows=%0d lresp=%b resp=%b want 2/0/0", i, lows, lresp, fresp); end
      if (i < 3) set_addr(2'b11, 1'b1, 16'(16'h0020 + 4 * (i + 1)), 3'd2);
    end
    @(negedge HCLK);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    set_addr(2'b10, 1'b0, 16'h0020, 3'd2);
    for (int i = 0; i < 4; i++) begin
      data_phase(32'h0);
      total++; if (rd !== exp_q[0]) begin bad++; $display("FAIL burst_read beat%0d: got %h want %h", i, rd, exp_q[0]); end
      void'(exp_q.pop_front());
      total++; if (lows !== 2 || wait_rd !== 32'h0) begin bad++; $display("FAIL burst_read_wait beat%0d: lows=%0d wait_rdata=%h want 2/0", i, lows, wait_rd); end
      if (i < 3) set_addr(2'b11, 1'b0, 16'(16'h0020 + 4 * (i + 1)), 3'd2);
    end
    @(negedge HCLK);
  endtask

  task automatic test_errors();
    cur = 2'd0;
    single(1'b1, 16'h0040, 3'd2, 32'h0BADF00D);
    single(1'b1, 16'h0040, 3'd3, 32'hFFFFFFFF);
    total++; if (lows !== 1 || lresp !== 1'b1 || fresp !== 1'b1) begin bad++; $display("FAIL err_size: lows=%0d lresp=%b resp=%b want 1/1/1", lows, lresp, fresp); end
    single(1'b1, 16'h0400, 3'd2, 32'hFFFFFFFF);
    total++; if (lows !== 1 || lresp !== 1'b1 || fresp !== 1'b1) begin bad++; $display("FAIL err_range: lows=%0d lresp=%b resp=%b want 1/1/1", lows, lresp, fresp); end
    single(1'b0, 16'h0040, 3'd2, 32'h0);
    total++; if (rd !== 32'h0BADF00D || fresp !== 1'b0) begin bad++; $display("FAIL err_nowrite: got %h resp=%b want 0badf00d/0", rd, fresp); end
    cur = 2'd1;
    single(1'b1, 16'h0022, 3'd2, 32'hFFFFFFFF);
    total++; if (lows !== 1 || lresp !== 1'b1 || fresp !== 1'b1) begin bad++; $display("FAIL err_ws2: lows=%0d lresp=%b resp=%b want 1/1/1", lows, lresp, fresp); end
    cur = 2'd0;
  endtask

  task automatic test_back_to_back();
    cur = 2'd0;
    set_addr(2'b10, 1'b1, 16'h0011, 3'd1);
    data_phase(32'hFFFFFFFF);
    total++; if (lows !== 1 || fresp !== 1'b1) begin bad++; $display("FAIL unaligned_err: lows=%0d resp=%b want 1/1", lows, fresp); end
    set_addr(2'b10, 1'b0, 16'h0010, 3'd2);
    data_phase(32'h0);
    total++; if (rd !== 32'hA5ADBEEF || fresp !== 1'b0 || lows !== 0) begin bad++; $display("FAIL read_in_err2: got %h resp=%b lows=%0d want a5adbeef/0/0", rd, fresp, lows); end
    @(negedge HCLK);
    set_addr(2'b10, 1'b1, 16'h0018, 3'd2);
    data_phase(32'hCAFEF00D);
    set_addr(2'b10, 1'b0, 16'h0018, 3'd2);
    data_phase(32'h0);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL write_then_read: got %h want cafef00d", rd); end
    @(negedge HCLK);
  endtask

  task automatic test_reset_mid_wait();
    cur = 2'd2;
    single(1'b1, 16'h0030, 3'd2, 32'h13579BDF);
    total++; if (lows !== 3 || fresp !== 1'b0) begin bad++; $display("FAIL ws3_write: lows=%0d resp=%b want 3/0", lows, fresp); end
    set_addr(2'b10, 1'b1, 16'h0030, 3'd2);
    @(posedge HCLK);
    @(negedge HCLK);
    hwdata = 32'hFFFF0000;
    set_idle();
    total++; if (m_ready !== 1'b0 || m_dbg !== 2'd1) begin bad++; $display("FAIL in_wait: ready=%b state=%0d want 0/1", m_ready, m_dbg); end
    HRESETn = 1'b0;
    #1;
    total++; if (m_ready !== 1'b1 || m_resp !== 1'b0) begin bad++; $display("FAIL reset_abort: ready=%b resp=%b want 1/0", m_ready, m_resp); end
    total++; if (m_dbg !== 2'd0) begin bad++; $display("FAIL reset_abort_state: got %0d want 0", m_dbg); end
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    single(1'b0, 16'h0030, 3'd2, 32'h0);
    total++; if (rd !== 32'h13579BDF || lows !== 3) begin bad++; $display("FAIL reset_nowrite: got %h lows=%0d want 13579bdf/3", rd, lows); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    cur = 2'd0;
    hwdata = 32'h0;
    set_idle();
    repeat (3) @(negedge HCLK);
    test_reset();
    HRESETn = 1'b1;
    @(negedge HCLK);
    test_word_rw();
    test_byte_lanes();
    test_burst_wait();
    test_errors();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/peripheral_ahb4_slave_mem.md
PERIPHERAL_AHB4_SLAVE_MEM -- requirements
Module: peripheral_ahb4_slave_mem

Interface
REQ-001 Parameter HADDR_SIZE, 16, address width in bits.
REQ-002 Parameter HDATA_SIZE, 32, data width in bits; power of two, 8..1024.
REQ-003 Parameter MEM_DEPTH, 256, number of HDATA_SIZE-bit words; power of two.
REQ-004 Parameter WAIT_STATES, 0, HREADYOUT-low cycles inserted per accepted OKAY beat; range 0..15.
REQ-005 Reset HRESETn, asynchronous, active-low; clock HCLK.
REQ-006 HCLK  in  1  bus clock; all state updates on its rising edge.
REQ-007 HRESETn  in  1  asynchronous active-low reset.
REQ-008 HSEL  in  1  slave select.
REQ-009 HADDR  in  HADDR_SIZE  byte address, address phase.
REQ-010 HWDATA  in  HDATA_SIZE  write data, data phase.
REQ-011 HWRITE  in  1  1=write, 0=read.
REQ-012 HSIZE  in  3  transfer size, 2^HSIZE bytes.
REQ-013 HBURST, HPROT, HMASTLOCK  in  3/4/1  accepted and ignored.
REQ-014 HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-015 HREADY  in  1  bus-level ready; address phase sampled only when 1.
REQ-016 HREADYOUT  out  1  slave ready; 0 extends the current data phase.
REQ-017 HRESP  out  1  0=OKAY, 1=ERROR.
REQ-018 HRDATA  out  HDATA_SIZE  read data.

Function
REQ-019 Transfer accepted on a rising edge when HSEL=1, HREADY=1, HTRANS[1]=1; HADDR, HSIZE and HWRITE are registered as data-phase controls.
REQ-020 IDLE/BUSY, or HSEL=0, with HREADY=1: next data phase is zero-wait OKAY (HREADYOUT=1, HRESP=0), no memory access.
REQ-021 Error checks at acceptance: HSIZE > log2(HDATA_SIZE/8); HADDR not aligned to 2^HSIZE; word index HADDR>>log2(HDATA_SIZE/8) >= MEM_DEPTH; any one marks the beat ERROR.
REQ-022 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-023 IDLE: accepted OKAY beat -> WAIT with counter=WAIT_STATES if WAIT_STATES>0, else stays IDLE with the data phase completing next cycle; accepted ERROR beat -> ERR1.
REQ-024 WAIT: HREADYOUT=0, HRESP=0; counter decrements each cycle; at counter=1 -> IDLE, data phase completes in the following cycle.
REQ-025 ERR1: HREADYOUT=0, HRESP=1, one cycle -> ERR2.
REQ-026 ERR2: HREADYOUT=1, HRESP=1, one cycle; a new transfer sampled in this cycle is accepted normally per REQ-023.
REQ-027 Write: in the completing data-phase cycle (HREADYOUT=1, HRESP=0), only the 2^HSIZE byte lanes selected by the registered address low bits are written from the same lanes of HWDATA; other bytes unchanged.
REQ-028 ERROR beats never modify memory.
REQ-029 Read: in the completing OKAY cycle, HRDATA = full stored word at the registered word index; unselected lanes carry stored data; HRDATA=0 in all other cycles.
REQ-030 Write completes on the edge ending its data phase, so a read accepted on that same edge returns the new data; no forwarding path is needed.
REQ-031 Wait states apply to every beat, including SEQ beats of a burst; no burst-address checking.
REQ-032 Memory contents are not initialised by reset.

Reset
REQ-033 While HRESETn=0: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, data-phase controls cleared (no pending transfer).
REQ-034 Reset asserted mid data phase (WAIT, ERR1, ERR2): transfer aborted, no memory write, outputs immediately take REQ-033 values.

Verification
REQ-035 WAIT_STATES=0: write NONSEQ word 0xDEADBEEF to 0x0010, then read 0x0010 -> HRDATA=0xDEADBEEF, HREADYOUT=1, HRESP=0, each beat in one cycle.
REQ-036 After REQ-035, byte write 0xA5 (HWDATA[31:24]) to 0x0013, read 0x0010 -> 0xA5ADBEEF.
REQ-037 WAIT_STATES=2: INCR4 word writes 0x1,0x2,0x3,0x4 at 0x0020 -> HREADYOUT low exactly 2 cycles per beat; INCR4 read returns 1,2,3,4.
REQ-038 HSIZE=3'b011 write to 0x0040, and word write to 0x0400 (MEM_DEPTH=256) -> each gives ERR1 (HREADYOUT=0,HRESP=1) then ERR2 (1,1); readback of 0x0040 unchanged.
REQ-039 Unaligned halfword write to 0x0011 -> two-cycle ERROR; back-to-back NONSEQ read sampled in ERR2 completes OKAY.
REQ-040 WAIT_STATES=3: assert HRESETn=0 during WAIT of a write to 0x0030 -> HREADYOUT=1, HRESP=0 at once; after release, read 0x0030 returns its pre-write value.
